// File: rtl/vec_ds_txreq_arb.sv
// Round-robin scheduler of per-slice downstream read requests with per-slice outstanding caps.
// Optional age priority over round-robin: define VEC_DS_TXREQ_AGE_EN.
module vec_ds_txreq_arb #(
    parameter int SLICE_NUM = 4,
    parameter int PLD_W     = 128,
    parameter int MAX_OS    = 16,
    parameter int OS_W      = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SLICE_NUM-1:0]       v_down_txreq_vld,
    input  logic [SLICE_NUM*PLD_W-1:0] v_down_txreq_pld,
    output logic [SLICE_NUM-1:0]       v_down_txreq_rdy,
    output logic                       down_txreq_vld,
    output logic [PLD_W+1:0]           down_txreq_pld,
    input  logic                       ds_input_txreq_rdy,
    input  logic                       rx_done_vld,
    input  logic [1:0]                 rx_done_slice,
    output logic [SLICE_NUM*OS_W-1:0]  os_cnt,
    output logic                       os_err
);

    logic [SLICE_NUM-1:0][OS_W-1:0] cnt_q;
    logic [SLICE_NUM-1:0]           elig;
    logic [SLICE_NUM-1:0]           rr_gnt;
    logic [SLICE_NUM-1:0]           gnt;
    logic [SLICE_NUM-1:0]           hs;
    logic [1:0]                     ptr_q;
    logic [1:0]                     rr_idx;
    logic                           rr_found;
    logic [1:0]                     gid;
    logic [PLD_W-1:0]               sel_pld;
    logic                           vld_q;
    logic [PLD_W+1:0]               pld_q;
    logic                           err_q;
    logic                           load;

    // Nothing is eligible while reset is held, so no handshake can leak through.
    always_comb begin
        elig = '0;
        for (int i = 0; i < SLICE_NUM; i++) begin
            elig[i] = v_down_txreq_vld[i] & (cnt_q[i] < OS_W'(MAX_OS)) & ~rst_n;
        end
    end

    always_comb begin
        rr_gnt   = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < SLICE_NUM; k++) begin
            rr_idx = ptr_q + 2'(k);
            if (!rr_found && elig[rr_idx]) begin
                rr_gnt[rr_idx] = 1'b1;
                rr_found       = 1'b1;
            end
        end
    end

`ifdef VEC_DS_TXREQ_AGE_EN
    localparam int AGE_TH = 8;

    logic [SLICE_NUM-1:0][3:0] wait_q;
    logic [SLICE_NUM-1:0]      aged;

    always_comb begin
        aged = '0;
        for (int i = 0; i < SLICE_NUM; i++) begin
            aged[i] = elig[i] & (wait_q[i] >= 4'(AGE_TH));
        end
    end

    // Aged slices win outright; lowest index among them.
    assign gnt = (|aged) ? (aged & (~aged + SLICE_NUM'(1))) : rr_gnt;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wait_q <= '0;
        end else begin
            for (int i = 0; i < SLICE_NUM; i++) begin
                if (hs[i]) begin
                    wait_q[i] <= '0;
                end else if (elig[i] && wait_q[i] != 4'hF) begin
                    wait_q[i] <= wait_q[i] + 4'd1;
                end
            end
        end
    end
`else
    assign gnt = rr_gnt;
`endif

    assign load             = ~vld_q | ds_input_txreq_rdy;
    assign hs               = gnt & {SLICE_NUM{load}};
    assign v_down_txreq_rdy = hs;

    always_comb begin
        gid = '0;
        for (int i = 0; i < SLICE_NUM; i++) begin
            if (gnt[i]) begin
                gid = 2'(i);
            end
        end
    end

    assign sel_pld = v_down_txreq_pld[gid*PLD_W +: PLD_W];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            vld_q <= 1'b0;
            pld_q <= '0;
        end else if (|hs) begin
            vld_q <= 1'b1;
            pld_q <= {gid, sel_pld};
        end else if (ds_input_txreq_rdy) begin
            vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ptr_q <= '0;
        end else if (|hs) begin
            ptr_q <= gid + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < SLICE_NUM; i++) begin
                logic dec;
                dec = rx_done_vld & (rx_done_slice == 2'(i)) & (cnt_q[i] != '0);
                if (hs[i] && !dec) begin
                    cnt_q[i] <= cnt_q[i] + OS_W'(1);
                end else if (dec && !hs[i]) begin
                    cnt_q[i] <= cnt_q[i] - OS_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            err_q <= 1'b0;
        end else if (rx_done_vld && cnt_q[rx_done_slice] == '0) begin
            err_q <= 1'b1;
        end
    end

    assign down_txreq_vld = vld_q;
    assign down_txreq_pld = pld_q;
    assign os_cnt         = cnt_q;
    assign os_err         = err_q;

endmodule

// File: tb/tb_vec_ds_txreq_arb.sv
// Directed scoreboard bench for vec_ds_txreq_arb.
// Expected grants are stated per step; forwarded payloads are queued and matched in order.
module tb_vec_ds_txreq_arb;

    localparam int PLD_W  = 128;
    localparam int OS_W   = 5;
`ifdef VEC_DS_TXREQ_AGE_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           v_vld;
    logic [PLD_W-1:0]     pld_in [4];
    logic [4*PLD_W-1:0]   pld_flat;
    logic [3:0]           v_rdy;
    logic                 d_vld;
    logic [PLD_W+1:0]     d_pld;
    logic                 ds_rdy;
    logic                 rx_vld;
    logic [1:0]           rx_slice;
    logic [4*OS_W-1:0]    os_cnt;
    logic                 os_err;

    int tests = 0;
    int fails = 0;
    logic [PLD_W+1:0] q[$];
    int exp_cnt [4];
    bit exp_err;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pld_flat[i*PLD_W +: PLD_W] = pld_in[i];
        end
    end

    vec_ds_txreq_arb #(
        .SLICE_NUM(4), .PLD_W(PLD_W), .MAX_OS(16), .OS_W(OS_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .v_down_txreq_vld(v_vld),
        .v_down_txreq_pld(pld_flat),
        .v_down_txreq_rdy(v_rdy),
        .down_txreq_vld(d_vld),
        .down_txreq_pld(d_pld),
        .ds_input_txreq_rdy(ds_rdy),
        .rx_done_vld(rx_vld),
        .rx_done_slice(rx_slice),
        .os_cnt(os_cnt),
        .os_err(os_err)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, advance model, then step past posedge.
    task automatic step(input int g, input string tag);
        logic [3:0] exp_rdy;
        @(negedge clk);
        if (q.size() != 0) begin
            chk({tag, ".vld"}, 256'(d_vld), 256'(1));
            chk({tag, ".pld"}, 256'(d_pld), 256'(q[0]));
        end else begin
            chk({tag, ".vld"}, 256'(d_vld), 256'(0));
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.cnt%0d", tag, i), 256'(os_cnt[i*OS_W +: OS_W]), 256'(exp_cnt[i]));
        end
        chk({tag, ".err"}, 256'(os_err), 256'(exp_err));
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk({tag, ".rdy"}, 256'(v_rdy), 256'(exp_rdy));
        if (ds_rdy && q.size() != 0) void'(q.pop_front());
        if (rx_vld) begin
            if (exp_cnt[rx_slice] == 0) exp_err = 1'b1;
            else exp_cnt[rx_slice]--;
        end
        if (g >= 0) begin
            q.push_back({g[1:0], pld_in[g]});
            exp_cnt[g]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        step(-1, "rst_a");
        q.delete();
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        exp_err = 1'b0;
        step(-1, "rst_b");
        chk("rst.pld", 256'(d_pld), 256'(0));
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b1;
        v_vld    = 4'b1111;
        ds_rdy   = 1'b1;
        rx_vld   = 1'b0;
        rx_slice = 2'd0;
        for (int i = 0; i < 4; i++) pld_in[i] = {$urandom, $urandom, $urandom, $urandom};
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single request from slice 2
        v_vld     = 4'b0100;
        pld_in[2] = 128'hA5;
        step(2, "single");
        v_vld = 4'b0000;
        step(-1, "single_out");
        step(-1, "single_idle");

        // Round-robin fairness
        do_reset();
        v_vld = 4'b1111;
        for (int k = 0; k < 8; k++) step(k % 4, $sformatf("rr%0d", k));

        // Downstream stall
        v_vld = 4'b0001;
        step(0, "pre_stall");
        ds_rdy = 1'b0;
        v_vld  = 4'b1111;
        for (int k = 0; k < 5; k++) step(-1, $sformatf("stall%0d", k));
        ds_rdy = 1'b1;
        step(1, "unstall");

        // Reset drops the pending output
        ds_rdy = 1'b0;
        do_reset();
        ds_rdy = 1'b1;

        // Outstanding cap on slice 1
        v_vld = 4'b0010;
        for (int k = 0; k < 16; k++) step(1, $sformatf("cap%0d", k));
        step(-1, "cap_block");
        rx_vld   = 1'b1;
        rx_slice = 2'd1;
        step(-1, "cap_rx");
        rx_vld = 1'b0;
        step(1, "cap_release");
        v_vld = 4'b0000;
        step(-1, "cap_full");

        // Simultaneous grant and completion, then an underflow completion
        do_reset();
        v_vld = 4'b1000;
        for (int k = 0; k < 5; k++) step(3, $sformatf("s3_%0d", k));
        rx_vld   = 1'b1;
        rx_slice = 2'd3;
        step(3, "s3_incdec");
        rx_vld = 1'b0;
        v_vld  = 4'b0000;
        step(-1, "s3_hold");
        rx_vld   = 1'b1;
        rx_slice = 2'd0;
        step(-1, "underflow");
        rx_vld = 1'b0;
        step(-1, "err_set");
        step(-1, "err_sticky");

        // Slice 2 ages while stalled alone, then competes with slices 0 and 1
        do_reset();
        v_vld = 4'b1000;
        step(3, "age_fill");
        v_vld  = 4'b0100;
        ds_rdy = 1'b0;
        for (int k = 0; k < 8; k++) step(-1, $sformatf("age_wait%0d", k));
        v_vld  = 4'b0111;
        ds_rdy = 1'b1;
        step(AGE ? 2 : 0, "age_win");
        step(AGE ? 0 : 1, "age_next");
        v_vld = 4'b0000;
        step(-1, "age_drain0");
        step(-1, "age_drain1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vec_ds_txreq_arb.md
Name: vec_ds_txreq_arb

Overview:
- Schedules the four hash-slice cache controllers' downstream read requests (AR/txreq) onto the single shared downstream txreq port.
- Arbitrates round-robin between slices and caps outstanding reads per slice.
- Tags each forwarded request with its 2-bit slice ID, so returning rxdata/completions can be steered back.
- Sits between the vec_cache_ctrl instances and the top-level down_txreq_* interface.

Parameters:
- SLICE_NUM, 4, number of hash slices (fixed at 4; SLICE_ID_W = 2).
- PLD_W, 128, width of one slice's txreq payload (addr+txnid+sideband).
- MAX_OS, 16, maximum outstanding reads per slice.
- OS_W, 5, outstanding counter width; must satisfy 2^OS_W > MAX_OS.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-high reset
- v_down_txreq_vld  in  4  per-slice request valid
- v_down_txreq_pld  in  4xPLD_W  per-slice request payload
- v_down_txreq_rdy  out  4  per-slice accept
- down_txreq_vld  out  1  downstream request valid
- down_txreq_pld  out  PLD_W+2  {slice_id[1:0], pld}
- ds_input_txreq_rdy  in  1  downstream ready
- rx_done_vld  in  1  one read fully returned (last beat written to linefill DB)
- rx_done_slice  in  2  slice owning the completed read
- os_cnt  out  4xOS_W  per-slice outstanding count
- os_err  out  1  sticky: completion received for a slice with os_cnt = 0

Behaviour:
- Reset values, all applied when rst_n = 1 at a clk edge:
  - down_txreq_vld = 0 and down_txreq_pld = 0.
  - os_cnt[*] = 0 and os_err = 0.
  - RR pointer = 0.
  - v_down_txreq_rdy = 0, because no slice is eligible while reset is asserted.
- Output stage:
  - Single registered slot holding down_txreq_vld/pld.
  - load = ~down_txreq_vld | ds_input_txreq_rdy, i.e. the slot is empty or is draining this cycle.
- Eligibility: slice i is eligible when v_down_txreq_vld[i] = 1 and os_cnt[i] < MAX_OS, using the registered count at the start of the cycle. A same-cycle completion does not make a capped slice eligible.
- Arbitration:
  - Combinational round-robin over the eligible slices, starting the search at the RR pointer.
  - At most one grant per cycle; grant is one-hot.
  - v_down_txreq_rdy[i] = grant[i] & load.
  - Upstream handshake completes when vld & rdy are both 1.
  - rdy may depend on vld; a slice's vld must not depend on its rdy.
- On a handshake with slice g:
  - down_txreq_vld <= 1 next cycle.
  - down_txreq_pld <= {g, pld[g]}.
  - RR pointer <= (g + 1) mod 4.
  - Latency from input handshake to down_txreq_vld is exactly 1 cycle.
- Without a handshake:
  - If ds_input_txreq_rdy = 1, down_txreq_vld <= 0.
  - Otherwise the output is held: vld and pld stay stable while stalled, as required downstream.
  - RR pointer is unchanged on idle cycles and unchanged when no slice is granted.
- Throughput: 1 request per cycle is sustainable when ds_input_txreq_rdy stays 1.
- Outstanding counters:
  - inc[i] = upstream handshake with slice i.
  - dec[i] = rx_done_vld & (rx_done_slice == i) & (os_cnt[i] != 0).
  - inc & dec in the same cycle leaves the count unchanged; inc alone adds 1; dec alone subtracts 1.
  - No wrap is possible, because inc is blocked at MAX_OS.
- Error condition: when rx_done_vld = 1 and os_cnt[rx_done_slice] = 0:
  - The counter stays 0.
  - os_err is set and stays set until reset.
- Reset mid-operation:
  - A pending output request is dropped: vld goes to 0 the cycle after reset.
  - All counters clear.
  - Upstream re-issues after reset.

Optional Feature:
- Macro: VEC_DS_TXREQ_AGE_EN.
- When defined:
  - Each slice has a 4-bit wait counter.
  - The counter increments on every cycle the slice is eligible but not granted, saturating at 15.
  - The counter clears when the slice is granted.
  - Any slice whose counter is ≥ AGE_TH (localparam, 8) takes absolute priority over round-robin.
  - Ties among aged slices go to the lowest index.
  - Granting an aged slice still updates the RR pointer to g+1.
- When undefined:
  - Pure round-robin as above.
  - No wait counters are synthesized.

Test Plan:
- Reset and single request: hold rst_n = 1 for 3 cycles, then vld = 4'b0100 with pld = 'hA5 and ds_rdy = 1.
  - Expect rdy[2] = 1 in cycle 0.
  - Expect down_txreq_vld = 1 with pld = {2'd2, 'hA5} in cycle 1.
  - Expect os_cnt[2] = 1.
- Round-robin fairness: all 4 slices held valid, ds_rdy = 1, 8 cycles.
  - Expect grant order 0,1,2,3,0,1,2,3.
  - Expect os_cnt = 2 for each slice.
- Downstream stall: ds_rdy = 0 for 5 cycles with a request loaded.
  - Expect down_txreq_vld/pld stable throughout.
  - Expect all v_down_txreq_rdy = 0.
  - When ds_rdy returns to 1, expect the next grant in the same cycle.
- Outstanding cap: slice 1 only, 16 grants with no rx_done.
  - Expect the 17th request blocked with rdy[1] = 0 and os_cnt[1] = 16.
  - Pulse rx_done with slice 1; expect os_cnt[1] = 15 next cycle and the request granted the following cycle.
- Simultaneous grant and completion: grant slice 3 in the same cycle as rx_done_slice = 3 while os_cnt[3] = 5.
  - Expect os_cnt[3] to remain 5.
  - Then send rx_done for slice 0 with os_cnt[0] = 0; expect os_err = 1 and os_cnt[0] = 0.
- VEC_DS_TXREQ_AGE_EN defined: slices 0 and 1 always valid; slice 2 valid but blocked by cap, then released.
  - Force slice 2's wait counter to 8 by holding it eligible-ungranted (set priority pointer adversarially).
  - Expect slice 2 granted on the next cycle ahead of round-robin.
